// File: rtl/act_serializer_pkg.sv
// ---------------------------------------------------------------------------
// act_serializer_pkg
//   Shared definitions for the bit-serial activation path.
//   The serializer, accumulator register and adder tree all import this
//   package, so the lane count and operand width defaults agree across blocks.
//
//   ACT_M_DEF  : default number of activation lanes (one per adder-tree input)
//   ACT_PA_DEF : default operand width, which is also the serial bit-cycles
//                per operand
//   ser_state_e: serializer FSM states
// ---------------------------------------------------------------------------
package act_serializer_pkg;

    localparam int ACT_M_DEF  = 16;
    localparam int ACT_PA_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } ser_state_e;

endpackage

// File: rtl/act_serializer_lane_buf.sv
// ---------------------------------------------------------------------------
// act_lane_buf
//   Single-entry pending buffer holding one full operand vector (all lanes).
//   It lets the upstream producer hand over the next operand while the
//   current one is still being shifted out.
//
//   Ports
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : drop the entry (flush); takes priority over write
//     wr_en      : capture wr_data and mark the entry full
//     wr_data    : operand vector, M lanes of Pa bits
//     rd_en      : entry consumed this cycle; it empties and its data clears
//     valid      : entry full
//     data       : stored operand vector
// ---------------------------------------------------------------------------
module act_lane_buf
    import act_serializer_pkg::*;
#(
    parameter int M  = ACT_M_DEF,
    parameter int Pa = ACT_PA_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [M*Pa-1:0] wr_data,
    input  logic            rd_en,
    output logic            valid,
    output logic [M*Pa-1:0] data
);

    logic            valid_q, valid_d;
    logic [M*Pa-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (rd_en) begin
            // Empty entries are kept at zero so a stale operand never lingers.
            valid_d = 1'b0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/act_serializer.sv
// ---------------------------------------------------------------------------
// act_serializer
//   Converts parallel activation operand vectors into LSB-first bit streams,
//   one bit per lane per cycle, and generates the control strobes for the
//   downstream shift-accumulate register.
//
//   Ports
//     clk, rst_n : clock, asynchronous active-low reset
//     in_valid   : in_act holds a valid operand vector
//     in_ready   : operand accepted this cycle (combinational)
//     in_act     : M lanes of Pa-bit two's complement operands, lane k at
//                  bits [k*Pa +: Pa]
//     flush      : abort current/pending operands, clear the accumulator
//     act_bits   : current serial bit of every lane
//     w_and_s    : accumulator write-and-shift enable
//     cl_en      : accumulator clear/load enable
//     msb_flag   : act_bits carries the sign bit (bit Pa-1)
//     res_valid  : accumulator holds a completed result this cycle
//
//   Handshake at cycle t in IDLE: bit n appears at t+1+n, res_valid at t+Pa+1.
//   A pending operand (or a handshake on the last bit) starts at count 0 the
//   cycle right after the last bit, so back-to-back operands have no bubble.
//   Pa must be at least 2.
// ---------------------------------------------------------------------------
module act_serializer
    import act_serializer_pkg::*;
#(
    parameter int M  = ACT_M_DEF,
    parameter int Pa = ACT_PA_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M*Pa-1:0] in_act,
    input  logic            flush,
    output logic [M-1:0]    act_bits,
    output logic            w_and_s,
    output logic            cl_en,
    output logic            msb_flag,
    output logic            res_valid
);

    localparam int             CW       = $clog2(Pa);
    localparam logic [CW-1:0]  CNT_LAST = CW'(Pa - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    ser_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q,   cnt_d;
    logic [M-1:0][Pa-1:0]   cur_q,   cur_d;     // lanes shift right, bit 0 = current bit

    logic [M-1:0]           act_bits_q,  act_bits_d;
    logic                   w_and_s_q,   w_and_s_d;
    logic                   cl_en_q,     cl_en_d;
    logic                   msb_flag_q,  msb_flag_d;
    logic                   res_valid_q, res_valid_d;

    // -----------------------------------------------------------------------
    // Pending buffer
    // -----------------------------------------------------------------------
    logic                   pend_valid;
    logic [M*Pa-1:0]        pend_data;
    logic                   pend_wr, pend_rd;
    logic [M-1:0][Pa-1:0]   in_lanes, pend_lanes;

    logic                   hs;
    logic                   last_bit;

    assign in_lanes   = in_act;
    assign pend_lanes = pend_data;

    assign in_ready = !pend_valid && (state_q != FLUSH) && !flush;
    assign hs       = in_valid && in_ready;
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // Park the operand only if the current one still has bits to go; a
    // handshake on the last bit loads the shift register directly instead.
    assign pend_wr = hs && (state_q == SHIFT) && !last_bit;
    assign pend_rd = last_bit && pend_valid && !flush;

    act_lane_buf #(
        .M  (M),
        .Pa (Pa)
    ) u_pend (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (pend_wr),
        .wr_data (in_act),
        .rd_en   (pend_rd),
        .valid   (pend_valid),
        .data    (pend_data)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;

        if (flush) begin
            state_d = FLUSH;
            cnt_d   = '0;
            cur_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hs) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        cur_d   = in_lanes;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        cnt_d = cnt_q + 1'b1;
                        for (int k = 0; k < M; k++) begin
                            cur_d[k] = cur_q[k] >> 1;
                        end
                    end else begin
                        cnt_d = '0;
                        if (pend_valid) begin
                            cur_d = pend_lanes;
                        end else if (hs) begin
                            cur_d = in_lanes;
                        end else begin
                            state_d = IDLE;
                            cur_d   = '0;
                        end
                    end
                end
                FLUSH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    cur_d   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs, derived from the next state so they line up with
    // the state they describe.
    // -----------------------------------------------------------------------
    always_comb begin
        act_bits_d = '0;
        if (state_d == SHIFT) begin
            for (int k = 0; k < M; k++) begin
                act_bits_d[k] = cur_d[k][0];
            end
        end
        w_and_s_d   = (state_d == SHIFT);
        cl_en_d     = ((state_d == SHIFT) && (cnt_d == '0)) || (state_d == FLUSH);
        msb_flag_d  = (state_d == SHIFT) && (cnt_d == CNT_LAST);
        // The accumulator finishes one cycle after the sign bit; a flush in
        // that last-bit cycle kills the result.
        res_valid_d = last_bit && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_q       <= '0;
            act_bits_q  <= '0;
            w_and_s_q   <= 1'b0;
            cl_en_q     <= 1'b0;
            msb_flag_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            act_bits_q  <= act_bits_d;
            w_and_s_q   <= w_and_s_d;
            cl_en_q     <= cl_en_d;
            msb_flag_q  <= msb_flag_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign act_bits  = act_bits_q;
    assign w_and_s   = w_and_s_q;
    assign cl_en     = cl_en_q;
    assign msb_flag  = msb_flag_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_act_serializer.sv
// ---------------------------------------------------------------------------
// tb_act_serializer
//   Scoreboard bench for act_serializer (M=16, Pa=8). Each accepted operand
//   pushes its expected per-cycle bit slices (with the cycle each is due) and
//   its expected res_valid cycle; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_act_serializer;

    localparam int M  = 16;
    localparam int PA = 8;

    typedef struct {
        int           due;
        logic [M-1:0] bits;
        logic         cl;
        logic         msb;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [M*PA-1:0] in_act = '0;
    logic            flush = 1'b0;
    logic [M-1:0]    act_bits;
    logic            w_and_s;
    logic            cl_en;
    logic            msb_flag;
    logic            res_valid;

    act_serializer #(.M(M), .Pa(PA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .flush     (flush),
        .act_bits  (act_bits),
        .w_and_s   (w_and_s),
        .cl_en     (cl_en),
        .msb_flag  (msb_flag),
        .res_valid (res_valid)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t sq[$];
    int   rq[$];
    int   last_end = 0;
    int   fl_from = -1;
    int   fl_to = -1;
    bit   mon_en = 1'b0;
    ent_t mon_e;
    logic mon_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected stream for an operand accepted at cycle t: it starts the cycle
    // after the handshake, or right after the previous operand's last bit.
    task automatic push(input logic [M*PA-1:0] op, input int t);
        int   start;
        ent_t e;
        start = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
        for (int n = 0; n < PA; n++) begin
            e.due = start + n;
            for (int k = 0; k < M; k++) e.bits[k] = op[k*PA + n];
            e.cl  = (n == 0);
            e.msb = (n == PA - 1);
            sq.push_back(e);
        end
        last_end = start + PA - 1;
        rq.push_back(start + PA);
    endtask

    task automatic send(input logic [M*PA-1:0] op);
        int n = 0;
        in_valid = 1'b1;
        in_act   = op;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("hs_timeout", 32'(in_ready), 32'd1);
        else           push(op, cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_act   = '0;
    endtask

    task automatic do_flush(input int hold);
        int t = cyc;
        flush   = 1'b1;
        fl_from = t + 1;
        fl_to   = t + hold;
        while (sq.size() > 0 && sq[sq.size()-1].due > t) sq.delete(sq.size()-1);
        while (rq.size() > 0 && rq[rq.size()-1] > t)     rq.delete(rq.size()-1);
        last_end = t;
        @(negedge clk);
        chk("rdy_in_flush", 32'(in_ready), 32'd0);
        repeat (hold) @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic do_reset(input int len);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        sq.delete();
        rq.delete();
        last_end = 0;
        fl_from  = -1;
        fl_to    = -1;
        #1;
        chk("rst_act_bits",  32'(act_bits),  32'd0);
        chk("rst_w_and_s",   32'(w_and_s),   32'd0);
        chk("rst_cl_en",     32'(cl_en),     32'd0);
        chk("rst_msb_flag",  32'(msb_flag),  32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        repeat (len) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every cycle's outputs against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                mon_res = (rq.size() > 0 && rq[0] == cyc);
                if (mon_res) rq.delete(0);
                chk("res_valid", 32'(res_valid), 32'(mon_res));
                if (sq.size() > 0 && sq[0].due == cyc) begin
                    mon_e = sq.pop_front();
                    chk("w_and_s",  32'(w_and_s),  32'd1);
                    chk("act_bits", 32'(act_bits), 32'(mon_e.bits));
                    chk("cl_en",    32'(cl_en),    32'(mon_e.cl));
                    chk("msb_flag", 32'(msb_flag), 32'(mon_e.msb));
                end else begin
                    chk("idle_w_and_s",  32'(w_and_s),  32'd0);
                    chk("idle_act_bits", 32'(act_bits), 32'd0);
                    chk("idle_msb_flag", 32'(msb_flag), 32'd0);
                    chk("idle_cl_en",    32'(cl_en),    32'(cyc >= fl_from && cyc <= fl_to));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic [M*PA-1:0] op;
        #2;
        do_reset(3);
        mon_en = 1'b1;

        // Single operand, lane 0 = A5.
        op = '0;
        op[7:0] = 8'hA5;
        send(op);
        idle(12);

        // Back-to-back: second operand parked while the first shifts.
        op = '0; op[7:0] = 8'h3C; op[5*PA +: PA] = 8'hF1;
        send(op);
        idle(2);
        op = '0; op[7:0] = 8'hC3; op[9*PA +: PA] = 8'h5A;
        send(op);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rdy_pend_full", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        chk("rdy_pend_drained", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        idle(10);

        // Handshake exactly on the last bit with nothing pending.
        op = '0; op[2*PA +: PA] = 8'h96;
        send(op);
        idle(7);
        op = '0; op[3*PA +: PA] = 8'h69;
        send(op);
        @(negedge clk);
        chk("rdy_direct_load", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        idle(10);

        // Flush at count 4 with the pending buffer full.
        op = '0; op[4*PA +: PA] = 8'hE7;
        send(op);
        idle(1);
        op = '0; op[6*PA +: PA] = 8'h18;
        send(op);
        idle(2);
        do_flush(1);
        @(negedge clk);
        chk("flush_cl_en",   32'(cl_en),   32'd1);
        chk("flush_w_and_s", 32'(w_and_s), 32'd0);
        @(negedge clk);
        chk("rdy_after_flush", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        idle(3);

        // Flush held for three cycles.
        op = '0; op[11*PA +: PA] = 8'h81;
        send(op);
        idle(3);
        do_flush(3);
        idle(3);

        // Reset mid-shift at count 3.
        op = '0; op[7:0] = 8'hFF; op[12*PA +: PA] = 8'h55;
        send(op);
        idle(3);
        do_reset(2);
        idle(12);

        // Sign lanes.
        op = '0; op[15*PA +: PA] = 8'h80; op[1*PA +: PA] = 8'h7F;
        send(op);
        idle(12);

        // Random stream with random gaps.
        for (int i = 0; i < 20; i++) begin
            op = {$urandom, $urandom, $urandom, $urandom};
            send(op);
            idle($urandom_range(0, 9));
        end
        idle(15);
        chk("sq_drained", 32'(sq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
